// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with hold-on-stall, flush and
// an optional two-entry skid buffer (head H, skid S); ctrl is zero on bubbles.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);
  logic              r_h_valid, r_s_valid;
  logic [DATA_W-1:0] r_h_data, r_s_data;
  logic [CTRL_W-1:0] r_h_ctrl, r_s_ctrl;
  logic [1:0]        r_occ;
  logic              w_acc, w_cons;
  logic [CTRL_W-1:0] w_ctrl;
  // Without a skid entry the only room comes from the head leaving this cycle.
  assign in_ready  = (SKID != 0) ? ~r_s_valid : (out_ready | ~r_h_valid);
  assign w_acc     = in_valid & in_ready;
  assign w_cons    = r_h_valid & out_ready;
  assign w_ctrl    = in_valid ? in_ctrl : '0;
  assign out_valid = r_h_valid;
  assign out_data  = r_h_data;
  assign out_ctrl  = r_h_valid ? r_h_ctrl : '0;
  assign occ       = r_occ;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_h_data  <= '0;
      r_s_data  <= '0;
      r_h_ctrl  <= '0;
      r_s_ctrl  <= '0;
      r_occ     <= '0;
    end else if (flush) begin
      r_h_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_h_ctrl  <= '0;
      r_s_ctrl  <= '0;
      r_occ     <= '0;
    end else begin
      r_occ <= r_occ + {1'b0, w_acc} - {1'b0, w_cons};
      if (w_cons && r_s_valid) begin
        r_h_data  <= r_s_data;
        r_h_ctrl  <= r_s_ctrl;
        r_s_valid <= 1'b0;
        r_s_ctrl  <= '0;
      end else if (w_acc && (!r_h_valid || w_cons)) begin
        r_h_valid <= 1'b1;
        r_h_data  <= in_data;
        r_h_ctrl  <= w_ctrl;
      end else if (w_acc) begin
        r_s_valid <= 1'b1;
        r_s_data  <= in_data;
        r_s_ctrl  <= w_ctrl;
      end else if (w_cons) begin
        r_h_valid <= 1'b0;
        r_h_ctrl  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives SKID=1 and SKID=0 instances with shared stimulus and
// checks both against queue-based FIFO models.
module tb_pipe_stage_reg;
  typedef logic [79:0] ent_t;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;
  logic        ir1, ov1, ir0, ov0;
  logic [63:0] od1, od0;
  logic [15:0] oc1, oc0;
  logic [1:0]  occ1, occ0;
  int          checks = 0, errors = 0;
  bit          armed = 0;
  ent_t        q1[$], q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occ(occ1));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .occ(occ0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input bit skid, input int n, input ent_t h,
                         input logic ir, input logic ov, input logic [63:0] od,
                         input logic [15:0] oc, input logic [1:0] on);
    chk({tag, "_in_ready"}, 64'(ir), 64'(skid ? (n < 2) : (out_ready || n == 0)));
    chk({tag, "_out_valid"}, 64'(ov), 64'(n > 0));
    chk({tag, "_out_ctrl"}, 64'(oc), (n > 0) ? 64'(h[15:0]) : 64'd0);
    chk({tag, "_occ"}, 64'(on), 64'(n));
    if (n > 0) chk({tag, "_out_data"}, od, h[79:16]);
  endtask

  task automatic cycle(input logic r, input logic fl, input logic iv, input logic ordy,
                       input logic [63:0] d, input logic [15:0] c);
    bit acc1, cons1, acc0, cons0;
    rst = r; flush = fl; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
    #1;
    if (armed) begin
      chk_dut("s1", 1'b1, q1.size(), (q1.size() > 0) ? q1[0] : '0, ir1, ov1, od1, oc1, occ1);
      chk_dut("s0", 1'b0, q0.size(), (q0.size() > 0) ? q0[0] : '0, ir0, ov0, od0, oc0, occ0);
    end
    acc1  = iv && q1.size() < 2;
    cons1 = ordy && q1.size() > 0;
    acc0  = iv && (ordy || q0.size() == 0);
    cons0 = ordy && q0.size() > 0;
    @(posedge clk);
    if (r || fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (cons1) void'(q1.pop_front());
      if (acc1) q1.push_back({d, iv ? c : 16'h0});
      if (cons0) void'(q0.pop_front());
      if (acc0) q0.push_back({d, iv ? c : 16'h0});
    end
    if (r) armed = 1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // reset and idle
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, $urandom_range(0, 1), 0, 0);
    // streaming
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 1, 64'(i), 16'($urandom));
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0, 0);
    // backpressure into skid
    cycle(0, 0, 1, 1, 64'hA, 16'h1);
    cycle(0, 0, 1, 0, 64'hB, 16'h2);
    chk("bp_occ", 64'(occ1), 64'd2);
    chk("bp_data", od1, 64'hA);
    cycle(0, 0, 1, 0, 64'hB, 16'h2);
    chk("bp_in_ready", 64'(ir1), 64'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
    // flush with pending entries
    cycle(0, 0, 1, 0, 64'hD1, 16'hFFFF);
    cycle(0, 0, 1, 0, 64'hD2, 16'hFFFF);
    cycle(0, 1, 1, 0, 64'hC, 16'hFFFF);
    chk("flush_ctrl", 64'(oc1), 64'd0);
    chk("flush_occ", 64'(occ1), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    // SKID=0 stall then replace
    cycle(0, 0, 1, 1, 64'h5, 16'h5);
    cycle(0, 0, 1, 0, 64'h6, 16'h6);
    chk("s0_hold", od0, 64'h5);
    cycle(0, 0, 1, 1, 64'h6, 16'h6);
    chk("s0_replace", od0, 64'h6);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    // reset priority over flush with a full skid
    cycle(0, 0, 1, 0, 64'hE1, 16'h11);
    cycle(0, 0, 1, 0, 64'hE2, 16'h22);
    cycle(1, 1, 1, 1, 64'hE3, 16'h33);
    chk("rst_occ", 64'(occ1), 64'd0);
    chk("rst_data", od1, 64'd0);
    cycle(0, 0, 1, 0, 64'h77, 16'h7);
    chk("post_rst_data", od1, 64'h77);
    cycle(0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, {$urandom, $urandom}, 16'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
